// File: rtl/game_status_ctrl_if.sv
// Game status bundle: mode/score/event inputs and display holder outputs.
interface game_status_ctrl_if;
    logic       ingameOn;
    logic       gameOver;
    logic       userquit;
    logic       match_pulse;
    logic [3:0] hex0hldr;
    logic [3:0] hex2hldr;
    logic [3:0] hex3hldr;
    logic [3:0] hex4hldr;
    logic [3:0] hex5hldr;
    logic [9:0] ledrhldr;
    logic [1:0] mode;

    modport master (
        output ingameOn, gameOver, userquit, match_pulse,
        input  hex0hldr, hex2hldr, hex3hldr, hex4hldr, hex5hldr,
        input  ledrhldr, mode
    );

    modport slave (
        input  ingameOn, gameOver, userquit, match_pulse,
        output hex0hldr, hex2hldr, hex3hldr, hex4hldr, hex5hldr,
        output ledrhldr, mode
    );
endinterface

// File: rtl/game_status_ctrl.sv
// Game mode FSM with BCD score/seconds counters driving display holders.
// Optional BLANK_LEAD_EN macro blanks zero tens digits.
module game_status_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic              clk,
    input  logic              resetn,
    game_status_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2,
        QUIT = 2'd3
    } state_e;

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);

    state_e        state_q, state_d;
    logic [3:0]    sc_one_q, sc_one_d;
    logic [3:0]    sc_ten_q, sc_ten_d;
    logic [3:0]    s_one_q, s_one_d;
    logic [3:0]    s_ten_q, s_ten_d;
    logic [TW-1:0] presc_q, presc_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          blk_ph_q, blk_ph_d;

    // Saturating two-digit BCD increment, returns {tens, ones}
    function automatic logic [7:0] bcd_inc(input logic [3:0] t,
                                           input logic [3:0] o);
        logic [7:0] r;
        r = {t, o};
        if (!(t == 4'd9 && o == 4'd9)) begin
            if (o == 4'd9) r = {t + 4'd1, 4'd0};
            else           r = {t, o + 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            sc_one_q  <= '0;
            sc_ten_q  <= '0;
            s_one_q   <= '0;
            s_ten_q   <= '0;
            presc_q   <= '0;
            blk_cnt_q <= '0;
            blk_ph_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_one_q  <= sc_one_d;
            sc_ten_q  <= sc_ten_d;
            s_one_q   <= s_one_d;
            s_ten_q   <= s_ten_d;
            presc_q   <= presc_d;
            blk_cnt_q <= blk_cnt_d;
            blk_ph_q  <= blk_ph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.userquit) begin
            state_d = QUIT;
        end else begin
            unique case (state_q)
                IDLE: if (bus.ingameOn && !bus.gameOver) state_d = PLAY;
                PLAY: begin
                    if (bus.gameOver)      state_d = OVER;
                    else if (!bus.ingameOn) state_d = IDLE;
                end
                OVER: if (!bus.ingameOn) state_d = IDLE;
                QUIT: if (!bus.ingameOn) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The final PLAY cycle still counts, so gate on state_q alone
    always_comb begin
        sc_one_d  = sc_one_q;
        sc_ten_d  = sc_ten_q;
        s_one_d   = s_one_q;
        s_ten_d   = s_ten_q;
        presc_d   = presc_q;
        blk_cnt_d = blk_cnt_q;
        blk_ph_d  = blk_ph_q;
        if (state_q == IDLE && state_d == PLAY) begin
            sc_one_d = '0;
            sc_ten_d = '0;
            s_one_d  = '0;
            s_ten_d  = '0;
            presc_d  = '0;
        end else if (state_q == PLAY) begin
            if (bus.match_pulse) {sc_ten_d, sc_one_d} = bcd_inc(sc_ten_q, sc_one_q);
            if (presc_q == TLAST) begin
                presc_d = '0;
                {s_ten_d, s_one_d} = bcd_inc(s_ten_q, s_one_q);
            end else begin
                presc_d = presc_q + TW'(1);
            end
        end
        if (state_q != OVER && state_d == OVER) begin
            blk_cnt_d = '0;
            blk_ph_d  = 1'b0;
        end else if (state_q == OVER) begin
            if (blk_cnt_q == BLAST) begin
                blk_cnt_d = '0;
                blk_ph_d  = ~blk_ph_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BW'(1);
            end
        end
    end

    logic [3:0] sc_ten_disp, s_ten_disp;

`ifdef BLANK_LEAD_EN
    assign sc_ten_disp = (sc_ten_q == 4'd0) ? 4'hF : sc_ten_q;
    assign s_ten_disp  = (s_ten_q == 4'd0) ? 4'hF : s_ten_q;
`else
    assign sc_ten_disp = sc_ten_q;
    assign s_ten_disp  = s_ten_q;
`endif

    always_comb begin
        bus.hex0hldr = 4'h0;
        bus.hex2hldr = sc_one_q;
        bus.hex3hldr = sc_ten_disp;
        bus.hex4hldr = s_one_q;
        bus.hex5hldr = s_ten_disp;
        bus.ledrhldr = 10'h000;
        bus.mode     = state_q;
        unique case (state_q)
            IDLE: bus.hex0hldr = 4'h0;
            PLAY: begin
                bus.hex0hldr = 4'h1;
                bus.ledrhldr = 10'h001 << s_one_q;
            end
            OVER: begin
                bus.hex0hldr = 4'hE;
                bus.ledrhldr = blk_ph_q ? 10'h000 : 10'h3FF;
            end
            QUIT: begin
                bus.hex0hldr = 4'hF;
                bus.hex2hldr = 4'hF;
                bus.hex3hldr = 4'hF;
                bus.hex4hldr = 4'hF;
                bus.hex5hldr = 4'hF;
            end
            default: bus.hex0hldr = 4'h0;
        endcase
    end

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl with TICK_DIV=10, BLINK_DIV=4.
module tb_game_status_ctrl;

    logic clk;
    logic resetn;
    int   n_chk;
    int   n_fail;

`ifdef BLANK_LEAD_EN
    localparam logic [3:0] TZ = 4'hF;
`else
    localparam logic [3:0] TZ = 4'h0;
`endif

    game_status_ctrl_if bus();

    game_status_ctrl #(
        .TICK_DIV  (10),
        .BLINK_DIV (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_disp(input string tag, input logic [3:0] h0,
                              input logic [3:0] h3, input logic [3:0] h2,
                              input logic [3:0] h5, input logic [3:0] h4,
                              input logic [9:0] led, input logic [1:0] md);
        check({tag, ".hex0"}, 32'(bus.hex0hldr), 32'(h0));
        check({tag, ".hex3"}, 32'(bus.hex3hldr), 32'(h3));
        check({tag, ".hex2"}, 32'(bus.hex2hldr), 32'(h2));
        check({tag, ".hex5"}, 32'(bus.hex5hldr), 32'(h5));
        check({tag, ".hex4"}, 32'(bus.hex4hldr), 32'(h4));
        check({tag, ".ledr"}, 32'(bus.ledrhldr), 32'(led));
        check({tag, ".mode"}, 32'(bus.mode), 32'(md));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        resetn = 1'b0;
        bus.ingameOn    = 1'b0;
        bus.gameOver    = 1'b0;
        bus.userquit    = 1'b0;
        bus.match_pulse = 1'b0;
        step(3);
        resetn = 1'b1;
        step(1);
        check_disp("rst0", 4'h0, TZ, 4'h0, TZ, 4'h0, 10'h000, 2'd0);

        // Reset mid-PLAY with score 37
        bus.ingameOn = 1'b1;
        step(1);
        bus.match_pulse = 1'b1;
        step(37);
        bus.match_pulse = 1'b0;
        step(1);
        check("pre_rst.hex3", 32'(bus.hex3hldr), 32'd3);
        check("pre_rst.hex2", 32'(bus.hex2hldr), 32'd7);
        bus.ingameOn = 1'b0;
        resetn = 1'b0;
        #1;
        check_disp("rst_async", 4'h0, TZ, 4'h0, TZ, 4'h0, 10'h000, 2'd0);
        step(1);
        resetn = 1'b1;
        step(5);
        check_disp("rst_idle", 4'h0, TZ, 4'h0, TZ, 4'h0, 10'h000, 2'd0);

        // Score count and saturation
        bus.ingameOn = 1'b1;
        step(1);
        check("play.mode", 32'(bus.mode), 32'd1);
        bus.match_pulse = 1'b1;
        step(12);
        bus.match_pulse = 1'b0;
        check("sc12.hex0", 32'(bus.hex0hldr), 32'h1);
        check("sc12.hex3", 32'(bus.hex3hldr), 32'h1);
        check("sc12.hex2", 32'(bus.hex2hldr), 32'h2);
        bus.match_pulse = 1'b1;
        step(100);
        bus.match_pulse = 1'b0;
        check("sc99.hex3", 32'(bus.hex3hldr), 32'h9);
        check("sc99.hex2", 32'(bus.hex2hldr), 32'h9);

        // Elapsed time and LEDR in a fresh game
        bus.ingameOn = 1'b0;
        step(1);
        check("idle_hold.hex2", 32'(bus.hex2hldr), 32'h9);
        bus.ingameOn = 1'b1;
        step(1);
        step(35);
        check_disp("t35", 4'h1, TZ, 4'h0, TZ, 4'h3, 10'h008, 2'd1);
        step(1000);
        check_disp("tsat", 4'h1, TZ, 4'h0, 4'h9, 4'h9, 10'h200, 2'd1);

        // Game over: 5 points, 1 second, then blink
        bus.ingameOn = 1'b0;
        step(1);
        bus.ingameOn = 1'b1;
        step(1);
        bus.match_pulse = 1'b1;
        step(5);
        bus.match_pulse = 1'b0;
        step(12);
        bus.gameOver = 1'b1;
        step(1);
        check_disp("over", 4'hE, TZ, 4'h5, TZ, 4'h1, 10'h3FF, 2'd2);
        bus.match_pulse = 1'b1;
        for (int k = 1; k < 16; k++) begin
            step(1);
            check($sformatf("blink%0d", k), 32'(bus.ledrhldr),
                  ((k / 4) % 2 == 0) ? 32'h3FF : 32'h000);
        end
        bus.match_pulse = 1'b0;
        check("over_frz.hex2", 32'(bus.hex2hldr), 32'h5);
        check("over_frz.hex4", 32'(bus.hex4hldr), 32'h1);
        bus.ingameOn = 1'b0;
        bus.gameOver = 1'b0;
        step(1);
        check_disp("over_idle", 4'h0, TZ, 4'h5, TZ, 4'h1, 10'h000, 2'd0);

        // Quit priority; the exit cycle pulse still scores
        bus.ingameOn = 1'b1;
        step(1);
        bus.match_pulse = 1'b1;
        step(3);
        bus.userquit = 1'b1;
        bus.gameOver = 1'b1;
        step(1);
        bus.match_pulse = 1'b0;
        check_disp("quit", 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 10'h000, 2'd3);
        bus.userquit = 1'b0;
        bus.gameOver = 1'b0;
        step(2);
        check("quit_stay.mode", 32'(bus.mode), 32'd3);
        bus.ingameOn = 1'b0;
        step(1);
        check_disp("quit_idle", 4'h0, TZ, 4'h4, TZ, 4'h0, 10'h000, 2'd0);

        // Leading-zero blanking: score 05, secs 07
        bus.ingameOn = 1'b1;
        step(1);
        bus.match_pulse = 1'b1;
        step(5);
        bus.match_pulse = 1'b0;
        step(70);
        check_disp("blank", 4'h1, TZ, 4'h5, TZ, 4'h7, 10'h080, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
